config_loader: RTL and testbench

CONFIG_LOADER -- requirements
Module: config_loader

---
 rtl/config_loader.sv | 163 ++++++++++++++++
 tb/tb_config_loader.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_loader.sv
// Word-fed configuration-chain loader: IDLE/LOAD/SHIFT/DONE serialiser.
// Optional readback capture of the chain tail when CONFIG_READBACK_EN is defined.
module config_loader #(
  parameter int unsigned CHAIN_LEN = 384,
  parameter int unsigned WORD_W    = 32
) (
  input  logic              Config_Clock,
  input  logic              Config_Reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              chain_out,
  output logic              chain_shift,
  input  logic              chain_in,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] readback_word,
  output logic              readback_valid
);

  localparam int unsigned CW = $clog2(CHAIN_LEN + 1);
  localparam int unsigned KW = $clog2(WORD_W + 1);
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     bitcnt_q, bitcnt_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [KW-1:0]     wcnt_q, wcnt_d;

  logic [31:0]       rem;
  logic [KW-1:0]     wbits;
  logic              accept;
  logic              shifting;
  logic              last_bit;

  // Bits the next word contributes: a full word, or what is left of the chain.
  always_comb begin
    rem   = CHAIN_LEN - 32'(bitcnt_q);
    wbits = (rem >= WORD_W) ? KW'(WORD_W) : KW'(rem);
  end

  assign accept   = (state_q == LOAD) & word_valid & ~abort;
  assign shifting = (state_q == SHIFT) & ~abort;
  assign last_bit = shifting & (wcnt_q == KW'(1));

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    sreg_d   = sreg_q;
    wcnt_d   = wcnt_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d  = LOAD;
            bitcnt_d = '0;
          end
        end
        LOAD: begin
          if (word_valid) begin
            sreg_d  = word_in;
            wcnt_d  = wbits;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          sreg_d   = sreg_q >> 1;
          bitcnt_d = bitcnt_q + CW'(1);
          wcnt_d   = wcnt_q - KW'(1);
          if (last_bit) begin
            state_d = (bitcnt_d == LAST) ? DONE : LOAD;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign word_ready  = (state_q == LOAD) & ~abort;
  assign chain_shift = shifting;
  assign chain_out   = shifting & sreg_q[0];
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE) & ~abort;

  always_ff @(posedge Config_Clock or negedge Config_Reset) begin
    if (!Config_Reset) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      sreg_q   <= '0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      sreg_q   <= sreg_d;
      wcnt_q   <= wcnt_d;
    end
  end

`ifdef CONFIG_READBACK_EN
  logic [WORD_W-1:0] rb_q, rb_d;
  logic [WORD_W-1:0] rbw_q, rbw_d;
  logic              rbv_q, rbv_d;
  logic [KW-1:0]     wlen_q, wlen_d;

  // Tail bits enter at the MSB; a short final word is right-aligned on output.
  always_comb begin
    rb_d   = rb_q;
    rbw_d  = rbw_q;
    rbv_d  = 1'b0;
    wlen_d = wlen_q;
    if (accept) begin
      wlen_d = wbits;
    end
    if (shifting) begin
      rb_d = {chain_in, rb_q[WORD_W-1:1]};
    end
    if (last_bit) begin
      rbv_d = 1'b1;
      rbw_d = rb_d >> (WORD_W - 32'(wlen_q));
    end
  end

  always_ff @(posedge Config_Clock or negedge Config_Reset) begin
    if (!Config_Reset) begin
      rb_q   <= '0;
      rbw_q  <= '0;
      rbv_q  <= 1'b0;
      wlen_q <= '0;
    end else begin
      rb_q   <= rb_d;
      rbw_q  <= rbw_d;
      rbv_q  <= rbv_d;
      wlen_q <= wlen_d;
    end
  end

  assign readback_word  = rbw_q;
  assign readback_valid = rbv_q;
`else
  logic unused_chain_in;

  assign unused_chain_in = chain_in;
  assign readback_word   = '0;
  assign readback_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: 64-bit chain scoreboard plus a 40-bit partial-word instance.
// Readback checks are active when CONFIG_READBACK_EN is defined.
module tb_config_loader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_start, a_abort, a_valid, a_ready;
  logic        a_out, a_shift, a_cin, a_busy, a_done, a_rbv;
  logic [31:0] a_word, a_rbw;

  logic        b_start, b_abort, b_valid, b_ready;
  logic        b_out, b_shift, b_cin, b_busy, b_done, b_rbv;
  logic [31:0] b_word, b_rbw;

  config_loader #(.CHAIN_LEN(64), .WORD_W(32)) u_a (
    .Config_Clock(clk), .Config_Reset(rst_n),
    .start(a_start), .abort(a_abort),
    .word_in(a_word), .word_valid(a_valid), .word_ready(a_ready),
    .chain_out(a_out), .chain_shift(a_shift), .chain_in(a_cin),
    .busy(a_busy), .done(a_done),
    .readback_word(a_rbw), .readback_valid(a_rbv)
  );

  config_loader #(.CHAIN_LEN(40), .WORD_W(32)) u_b (
    .Config_Clock(clk), .Config_Reset(rst_n),
    .start(b_start), .abort(b_abort),
    .word_in(b_word), .word_valid(b_valid), .word_ready(b_ready),
    .chain_out(b_out), .chain_shift(b_shift), .chain_in(b_cin),
    .busy(b_busy), .done(b_done),
    .readback_word(b_rbw), .readback_valid(b_rbv)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // 64-bit chain model: head at bit 63, tail at bit 0
  logic [63:0] chain_m = '0;
  always @(posedge clk) if (a_shift) chain_m <= {a_out, chain_m[63:1]};
  assign a_cin = chain_m[0];
  assign b_cin = 1'b1;

  bit          exp_q[$];
  logic [31:0] rb_q[$];
  int          a_shifts = 0;
  int          a_dones = 0;

  always @(negedge clk) begin
    if (a_shift) begin
      a_shifts <= a_shifts + 1;
      if (exp_q.size() == 0) chk("unexpected_shift", 1, 0);
      else chk("chain_out", a_out, exp_q.pop_front());
    end else begin
      chk("chain_out_quiet", a_out, 0);
    end
    if (a_done) a_dones <= a_dones + 1;
`ifdef CONFIG_READBACK_EN
    if (a_rbv) begin
      if (rb_q.size() == 0) chk("unexpected_rb", 1, 0);
      else chk("readback_word", a_rbw, rb_q.pop_front());
    end
`else
    chk("rb_tied", {a_rbv, a_rbw}, 0);
`endif
  end

  logic [63:0] b_bits = '0;
  int          b_n = 0;
  int          b_dones = 0;
  logic [31:0] b_rbs[$];
  always @(negedge clk) begin
    if (b_shift) begin
      if (b_n < 64) b_bits[b_n] <= b_out;
      b_n <= b_n + 1;
    end
    if (b_done) b_dones <= b_dones + 1;
    if (b_rbv) b_rbs.push_back(b_rbw);
  end

  task automatic push_bits(input logic [31:0] w);
    for (int i = 0; i < 32; i++) exp_q.push_back(w[i]);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!a_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", a_ready, 1);
  endtask

  task automatic wait_done(output int t);
    int n = 0;
    @(negedge clk);
    while (!a_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", a_done, 1);
    t = cyc;
  endtask

  task automatic run_session(input logic [31:0] w0, input logic [31:0] w1,
                             input int gap, input int exp_off);
    int t0, t1, s0, d0;
    @(posedge clk); #1;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    a_word  = w0;
    a_valid = 1'b1;
    push_bits(w0);
    s0 = a_shifts;
    d0 = a_dones;
`ifdef CONFIG_READBACK_EN
    rb_q.push_back(chain_m[31:0]);
    rb_q.push_back(chain_m[63:32]);
`endif
    chk("load_busy_ready", {a_busy, a_ready, a_shift}, 3'b110);
    wait_ready();
    t0 = cyc;
    @(posedge clk); #1;
    if (gap > 0) a_valid = 1'b0;
    else a_word = w1;
    push_bits(w1);
    wait_ready();
    for (int i = 0; i < gap; i++) begin
      chk("stall_ready_noshift", {a_ready, a_shift}, 2'b10);
      @(posedge clk); #1;
      if (i == gap - 1) begin
        a_word  = w1;
        a_valid = 1'b1;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    wait_done(t1);
    chk("done_latency", t1 - t0, exp_off);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_after_done", {a_busy, a_done}, 0);
    chk("shift_count", a_shifts - s0, 64);
    chk("done_pulses", a_dones - d0, 1);
    chk("bits_consumed", exp_q.size(), 0);
`ifdef CONFIG_READBACK_EN
    chk("rb_pulses", rb_q.size(), 0);
`endif
  endtask

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    int          gap;
    int          off;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int s0, d0, t0, n;
    tbl[0] = '{32'hDEADBEEF, 32'h12345678, 0, 66};
    tbl[1] = '{32'hA5A5A5A5, 32'h0F0F0F0F, 7, 73};
    tbl[2] = '{32'hFFFFFFFF, 32'h00000000, 0, 66};
    tbl[3] = '{32'h00000001, 32'h80000000, 3, 69};
    tbl[4] = '{32'hCAFEF00D, 32'hCAFEF00D, 0, 66};
    tbl[5] = '{32'hCAFEF00D, 32'hCAFEF00D, 1, 67};

    rst_n = 1'b0;
    {a_start, a_abort, a_valid} = '0;
    {b_start, b_abort, b_valid} = '0;
    a_word = '0;
    b_word = '0;
    #1;
    chk("reset_a", {a_busy, a_ready, a_shift, a_out, a_done, a_rbv, a_rbw}, 0);
    chk("reset_b", {b_busy, b_ready, b_shift, b_out, b_done, b_rbv, b_rbw}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {a_busy, a_ready, a_shift}, 0);

    for (int v = 0; v < 6; v++)
      run_session(tbl[v].w0, tbl[v].w1, tbl[v].gap, tbl[v].off);

    // reset asserted in the 10th SHIFT cycle
    @(posedge clk); #1;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    a_word  = 32'h13579BDF;
    a_valid = 1'b1;
    push_bits(32'h13579BDF);
    wait_ready();
    @(posedge clk); #1;
    a_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    chk("mid_shift_active", a_shift, 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outs", {a_busy, a_shift, a_out, a_ready, a_done, a_rbv}, 0);
    chk("async_reset_rbw", a_rbw, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("idle_after_reset2", a_busy, 0);
    run_session(tbl[0].w0, tbl[0].w1, tbl[0].gap, tbl[0].off);

    // abort with start during SHIFT bit 5
    @(posedge clk); #1;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    a_word  = 32'h2468ACE1;
    a_valid = 1'b1;
    push_bits(32'h2468ACE1);
    wait_ready();
    s0 = a_shifts;
    d0 = a_dones;
    @(posedge clk); #1;
    a_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    a_abort = 1'b1;
    a_start = 1'b1;
    @(negedge clk);
    chk("abort_noshift", {a_shift, a_out, a_ready, a_done}, 0);
    @(posedge clk); #1;
    a_abort = 1'b0;
    a_start = 1'b0;
    @(negedge clk);
    chk("abort_idle", a_busy, 0);
    repeat (3) @(negedge clk);
    chk("abort_stays_idle", a_busy, 0);
    chk("abort_shift_count", a_shifts - s0, 4);
    chk("abort_no_done", a_dones - d0, 0);
    exp_q.delete();
    run_session(tbl[2].w0, tbl[2].w1, tbl[2].gap, tbl[2].off);

    // 40-bit chain: final word shifts only 8 bits
    @(posedge clk); #1;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    b_word  = 32'hFFFFFFFF;
    b_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!b_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("b_ready_wait", b_ready, 1);
    t0 = cyc;
    @(posedge clk); #1;
    b_word = 32'h000000AB;
    n = 0;
    @(negedge clk);
    while (!b_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("b_done_wait", b_done, 1);
    chk("b_done_latency", cyc - t0, 42);
    @(posedge clk); #1;
    b_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("b_shift_count", b_n, 40);
    chk("b_bits", b_bits, {24'h0, 8'hAB, 32'hFFFFFFFF});
    chk("b_done_pulses", b_dones, 1);
    chk("b_idle", {b_busy, b_ready}, 0);
`ifdef CONFIG_READBACK_EN
    chk("b_rb_count", b_rbs.size(), 2);
    if (b_rbs.size() == 2) begin
      chk("b_rb_full", b_rbs[0], 32'hFFFFFFFF);
      chk("b_rb_partial", b_rbs[1], 32'h000000FF);
    end
`else
    chk("b_rb_count", b_rbs.size(), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
